// File: rtl/life_pkg.sv
// Shared encodings for the Game-of-Life engine: commands, FSM states,
// render characters and the fixed neighbour visiting order.
package life_pkg;

  typedef enum logic [1:0] {
    CMD_INIT  = 2'd0,
    CMD_STEP  = 2'd1,
    CMD_DUMP  = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_CLEAR, S_STEP, S_HOME, S_ROW, S_EOL
  } state_e;

  localparam logic [7:0] CH_ALIVE = 8'h4F;
  localparam logic [7:0] CH_DEAD  = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  // ESC [ H : cursor home
  function automatic logic [7:0] home_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h1B;
      2'd1:    return 8'h5B;
      default: return 8'h48;
    endcase
  endfunction

  function automatic logic [7:0] cell_char(input logic alive);
    return alive ? CH_ALIVE : CH_DEAD;
  endfunction

  // Offset codes 0=-1, 1=0, 2=+1 for read order NW,N,NE,W,E,SW,S,SE
  function automatic logic [1:0] nb_dx(input logic [2:0] p);
    case (p)
      3'd0, 3'd3, 3'd5: return 2'd0;
      3'd1, 3'd6:       return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] nb_dy(input logic [2:0] p);
    case (p)
      3'd0, 3'd1, 3'd2: return 2'd0;
      3'd3, 3'd4:       return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/life_engine_if.sv
// Host command / render stream bundle between the engine and its UART side.
interface life_engine_if #(
  parameter int GEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd;
  logic [8:0]       birth_mask;
  logic [8:0]       survive_mask;
  logic             rng;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             busy;
  logic [GEN_W-1:0] generation;

  modport master (
    output cmd_valid, cmd, birth_mask, survive_mask, rng, out_ready,
    input  cmd_ready, out_valid, out_data, busy, generation
  );

  modport slave (
    input  cmd_valid, cmd, birth_mask, survive_mask, rng, out_ready,
    output cmd_ready, out_valid, out_data, busy, generation
  );
endinterface

// File: rtl/life_board_mem.sv
// Two banks of 2**AW one-bit cells: combinational read, synchronous write.
module life_board_mem #(
  parameter int AW = 9
) (
  input  logic          clk_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          rd_bank_i,
  output logic          rd_data_o,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          wr_bank_i,
  input  logic          wr_data_i
);
  logic [1:0][(1<<AW)-1:0] mem_q;

  assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
  end
endmodule

// File: rtl/life_engine.sv
// Game-of-Life engine: INIT/CLEAR/STEP/DUMP over a ping-pong cell store.
// Define LIFE_TORUS_EN for a toroidal board; otherwise off-board neighbours read dead.
module life_engine
  import life_pkg::*;
#(
  parameter int LOG_W = 5,
  parameter int LOG_H = 4,
  parameter int GEN_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  life_engine_if.slave bus
);
  localparam int AW = LOG_W + LOG_H;

  state_e           state_q;
  logic [AW-1:0]    cell_q;
  logic [3:0]       phase_q;
  logic [3:0]       cnt_q;
  logic [1:0]       sub_q;
  logic             bank_q;
  logic [GEN_W-1:0] gen_q;
  logic [8:0]       birth_q, survive_q;
  logic             cmd_ready_q, busy_q, out_valid_q;
  logic [7:0]       out_data_q;

  logic [LOG_W-1:0] cx, nx;
  logic [LOG_H-1:0] cy, ny;
  logic [1:0]       dxc, dyc;
  logic             edge_kill, nb_alive, next_cell;
  logic [AW-1:0]    rd_addr_d;
  logic             rd_data, we_d, wr_bank_d, wr_data_d;

  assign cx  = cell_q[LOG_W-1:0];
  assign cy  = cell_q[AW-1:LOG_W];
  assign dxc = nb_dx(phase_q[2:0]);
  assign dyc = nb_dy(phase_q[2:0]);
  // Offsets wrap naturally in LOG_W/LOG_H bits; the flat board masks the wrap off
  assign nx  = cx + LOG_W'(dxc) - LOG_W'(1);
  assign ny  = cy + LOG_H'(dyc) - LOG_H'(1);

`ifdef LIFE_TORUS_EN
  assign edge_kill = 1'b0;
`else
  assign edge_kill = (dxc == 2'd0 && cx == '0) || (dxc == 2'd2 && (&cx)) ||
                     (dyc == 2'd0 && cy == '0) || (dyc == 2'd2 && (&cy));
`endif

  assign nb_alive  = rd_data & ~edge_kill;
  assign next_cell = rd_data ? survive_q[cnt_q] : birth_q[cnt_q];

  // Render reads one cell ahead so the next byte is ready at each transfer
  always_comb begin
    rd_addr_d = cell_q;
    case (state_q)
      S_STEP:       if (phase_q != 4'd8) rd_addr_d = {ny, nx};
      S_ROW, S_EOL: rd_addr_d = cell_q + 1'b1;
      default:      ;
    endcase
  end

  assign we_d      = !reset && (state_q == S_INIT || state_q == S_CLEAR ||
                                (state_q == S_STEP && phase_q == 4'd8));
  assign wr_bank_d = (state_q == S_STEP) ? ~bank_q : bank_q;
  assign wr_data_d = (state_q == S_INIT) ? bus.rng :
                     (state_q == S_STEP) ? next_cell : 1'b0;

  life_board_mem #(.AW(AW)) u_mem (
    .clk_i     (clk),
    .rd_addr_i (rd_addr_d),
    .rd_bank_i (bank_q),
    .rd_data_o (rd_data),
    .we_i      (we_d),
    .wr_addr_i (cell_q),
    .wr_bank_i (wr_bank_d),
    .wr_data_i (wr_data_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cell_q      <= '0;
      phase_q     <= '0;
      cnt_q       <= '0;
      sub_q       <= '0;
      bank_q      <= 1'b0;
      gen_q       <= '0;
      birth_q     <= '0;
      survive_q   <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          cell_q      <= '0;
          phase_q     <= '0;
          cnt_q       <= '0;
          sub_q       <= '0;
          case (cmd_e'(bus.cmd))
            CMD_INIT: state_q <= S_INIT;
            CMD_STEP: begin
              state_q   <= S_STEP;
              birth_q   <= bus.birth_mask;
              survive_q <= bus.survive_mask;
            end
            CMD_DUMP: begin
              state_q     <= S_HOME;
              out_valid_q <= 1'b1;
              out_data_q  <= home_byte(2'd0);
            end
            default: state_q <= S_CLEAR;
          endcase
        end
        S_INIT, S_CLEAR: begin
          cell_q <= cell_q + 1'b1;
          if (&cell_q) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        S_STEP: begin
          if (phase_q == 4'd8) begin
            phase_q <= '0;
            cnt_q   <= '0;
            cell_q  <= cell_q + 1'b1;
            if (&cell_q) begin
              state_q     <= S_IDLE;
              bank_q      <= ~bank_q;
              gen_q       <= gen_q + 1'b1;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
            cnt_q   <= cnt_q + {3'b000, nb_alive};
          end
        end
        S_HOME: if (bus.out_ready) begin
          if (sub_q == 2'd2) begin
            state_q    <= S_ROW;
            out_data_q <= cell_char(rd_data);
          end else begin
            sub_q      <= sub_q + 1'b1;
            out_data_q <= home_byte(sub_q + 1'b1);
          end
        end
        S_ROW: if (bus.out_ready) begin
          if (&cx) begin
            state_q    <= S_EOL;
            sub_q      <= 2'd0;
            out_data_q <= CH_CR;
          end else begin
            cell_q     <= cell_q + 1'b1;
            out_data_q <= cell_char(rd_data);
          end
        end
        S_EOL: if (bus.out_ready) begin
          if (sub_q == 2'd0) begin
            sub_q      <= 2'd1;
            out_data_q <= CH_LF;
          end else if (&cell_q) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end else begin
            state_q    <= S_ROW;
            cell_q     <= cell_q + 1'b1;
            out_data_q <= cell_char(rd_data);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.busy       = busy_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.generation = gen_q;

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench for life_engine: expected render bytes are queued per DUMP
// and popped by a stream monitor as bytes transfer.
module tb_life_engine;
  import life_pkg::*;

  localparam int LOG_W = 5;
  localparam int LOG_H = 4;
  localparam int GEN_W = 16;
  localparam int W = 1 << LOG_W;
  localparam int H = 1 << LOG_H;
  localparam int N = W * H;
  localparam int STEP_CYC = 9 * N;
  localparam int DUMP_BYTES = 3 + H * (W + 2);

  logic clk = 1'b0;
  logic reset = 1'b1;
  life_engine_if #(.GEN_W(GEN_W)) bus();

  life_engine #(.LOG_W(LOG_W), .LOG_H(LOG_H), .GEN_W(GEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rx_count = 0;
  logic [7:0] sb[$];
  logic [7:0] mon_exp;
  logic mdl [H][W];
  logic pat [N];
  logic [GEN_W-1:0] exp_gen;

  // Stream monitor: a byte transfers at the next edge when valid & ready
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL stream_extra got=%02h exp=none idx=%0d", bus.out_data, rx_count);
      end else begin
        mon_exp = sb.pop_front();
        if (bus.out_data !== mon_exp) begin
          failures++;
          $display("FAIL stream_byte idx=%0d got=%02h exp=%02h", rx_count, bus.out_data, mon_exp);
        end
      end
      rx_count++;
    end
  end

  task automatic send_cmd(input logic [1:0] c);
    int t;
    t = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_wait got=%b exp=1", bus.cmd_ready);
    end
    bus.cmd = c;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && cyc < limit) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic push_dump();
    sb.push_back(8'h1B);
    sb.push_back(8'h5B);
    sb.push_back(8'h48);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) sb.push_back(mdl[y][x] ? 8'h4F : 8'h20);
      sb.push_back(8'h0D);
      sb.push_back(8'h0A);
    end
  endtask

  task automatic clear_model();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) mdl[y][x] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_gen = '0;
  endtask

  task automatic do_init();
    send_cmd(CMD_INIT);
    for (int k = 0; k < N; k++) begin
      bus.rng = pat[k];
      @(posedge clk);
      #1;
    end
    bus.rng = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL init_done busy=%b exp=0", bus.busy);
    end
    for (int k = 0; k < N; k++) mdl[k / W][k % W] = pat[k];
  endtask

  task automatic do_step(input logic [8:0] b, input logic [8:0] s, input bit perturb);
    int cyc;
    bus.birth_mask = b;
    bus.survive_mask = s;
    send_cmd(CMD_STEP);
    if (perturb) begin
      bus.birth_mask = ~b;
      bus.survive_mask = ~s;
    end
    wait_idle(STEP_CYC + 100, cyc);
    exp_gen = exp_gen + 1'b1;
    checks++;
    if (cyc != STEP_CYC) begin
      failures++;
      $display("FAIL step_cycles got=%0d exp=%0d", cyc, STEP_CYC);
    end
    checks++;
    if (bus.generation !== exp_gen) begin
      failures++;
      $display("FAIL step_generation got=%0d exp=%0d", bus.generation, exp_gen);
    end
  endtask

  task automatic do_dump();
    int cyc;
    push_dump();
    rx_count = 0;
    send_cmd(CMD_DUMP);
    wait_idle(DUMP_BYTES + 100, cyc);
    checks++;
    if (cyc != DUMP_BYTES || rx_count != DUMP_BYTES || sb.size() != 0) begin
      failures++;
      $display("FAIL dump_len busy_cyc=%0d bytes=%0d left=%0d exp=%0d", cyc, rx_count, sb.size(), DUMP_BYTES);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.generation !== '0 || bus.out_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_values rdy=%b busy=%b ov=%b gen=%0d od=%02h exp=1/0/0/0/00",
               bus.cmd_ready, bus.busy, bus.out_valid, bus.generation, bus.out_data);
    end
    reset = 1'b0;
    exp_gen = '0;
    send_cmd(CMD_STEP);
    repeat (100) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL step_running busy=%b rdy=%b exp=1/0", bus.busy, bus.cmd_ready);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.generation !== '0) begin
      failures++;
      $display("FAIL reset_mid_step busy=%b rdy=%b gen=%0d exp=0/1/0", bus.busy, bus.cmd_ready, bus.generation);
    end
    reset = 1'b0;
  endtask

  task automatic test_clear_dump();
    int cyc;
    send_cmd(CMD_CLEAR);
    wait_idle(N + 100, cyc);
    checks++;
    if (cyc != N) begin
      failures++;
      $display("FAIL clear_cycles got=%0d exp=%0d", cyc, N);
    end
    clear_model();
    do_dump();
  endtask

  task automatic test_blinker();
    for (int k = 0; k < N; k++) pat[k] = 1'b0;
    pat[2 * W + 1] = 1'b1;
    pat[2 * W + 2] = 1'b1;
    pat[2 * W + 3] = 1'b1;
    do_init();
    do_step(9'h008, 9'h00C, 1'b0);
    clear_model();
    mdl[1][2] = 1'b1;
    mdl[2][2] = 1'b1;
    mdl[3][2] = 1'b1;
    do_dump();
  endtask

  task automatic test_edge();
    for (int k = 0; k < N; k++) pat[k] = 1'b0;
    pat[5 * W + 31] = 1'b1;
    pat[5 * W + 0] = 1'b1;
    pat[5 * W + 1] = 1'b1;
    do_init();
    do_step(9'h008, 9'h00C, 1'b0);
    clear_model();
`ifdef LIFE_TORUS_EN
    mdl[4][0] = 1'b1;
    mdl[5][0] = 1'b1;
    mdl[6][0] = 1'b1;
`endif
    do_dump();
  endtask

  task automatic test_still_life();
    do_reset();
    for (int k = 0; k < N; k++) pat[k] = 1'($urandom_range(0, 1));
    do_init();
    do_step(9'h000, 9'h1FF, 1'b0);
    do_step(9'h000, 9'h1FF, 1'b1);
    do_step(9'h000, 9'h1FF, 1'b0);
    do_dump();
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    int cyc;
    push_dump();
    rx_count = 0;
    send_cmd(CMD_DUMP);
    cyc = 0;
    while (rx_count < 40 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    held = bus.out_data;
    checks++;
    if (sb.size() == 0 || held !== sb[0]) begin
      failures++;
      $display("FAIL stall_byte got=%02h rx=%0d", held, rx_count);
    end
    bus.cmd = CMD_CLEAR;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d ov=%b od=%02h rdy=%b exp=1/%02h/0",
                 i, bus.out_valid, bus.out_data, bus.cmd_ready, held);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle(DUMP_BYTES + 200, cyc);
    checks++;
    if (rx_count != DUMP_BYTES || sb.size() != 0) begin
      failures++;
      $display("FAIL stall_dump_len bytes=%0d left=%0d exp=%0d", rx_count, sb.size(), DUMP_BYTES);
    end
    sb.delete();
    do_dump();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd = 2'd0;
    bus.birth_mask = 9'h000;
    bus.survive_mask = 9'h000;
    bus.rng = 1'b0;
    bus.out_ready = 1'b1;
    exp_gen = '0;
    test_reset();
    test_clear_dump();
    test_blinker();
    test_edge();
    test_still_life();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
